dmem_arbiter: RTL and testbench

Shares the single-port data memory between the MIPS core and a host port used for debug, test loading and DMA. The core has priority by default. A starvation counter guarantees the host a slot by stalling the core for exactly one cycle. The block sits between the core's data-memory interface and the data memory. The memory has a combinational read and a write on the clock edge.

---
 rtl/dmem_arbiter.sv | 99 +++++++++
 tb/tb_dmem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core and a host port.
// The core has priority; a wait counter forces one host slot by stalling the core.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_memread,
  input  logic        cpu_memwrite,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_rvalid,
  output logic [31:0] host_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned DATA_W = 32;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_cnt_nxt;
  logic              cpu_acc;
  logic              at_limit;
  logic              host_force;
  logic              host_grant;
  logic              rvalid_nxt;
  logic [DATA_W-1:0] rdata_nxt;

  // With no wait budget the host is always at its limit; avoids a constant compare.
  generate
    if (MAX_WAIT == 0) begin : g_no_wait
      assign at_limit = 1'b1;
    end else begin : g_wait
      assign at_limit = (wait_cnt >= CNT_LIMIT);
    end
  endgenerate

  // Grant decision and memory port mux.
  always_comb begin
    cpu_acc    = cpu_memread | cpu_memwrite;
    host_force = host_valid & at_limit;
    host_grant = host_valid & (~cpu_acc | host_force);
    host_ready = host_grant;
    cpu_stall  = host_force & cpu_acc;
    cpu_rdata  = mem_rdata;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    mem_we     = cpu_memwrite;
    if (host_grant) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_we    = host_we;
    end
  end

  // Wait counter: clears on acceptance or an idle host, otherwise saturating count.
  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (!host_valid || host_grant) begin
      wait_cnt_nxt = '0;
    end else if (wait_cnt != CNT_MAX) begin
      wait_cnt_nxt = wait_cnt + CNT_W'(1);
    end
  end

  // Read return captured one cycle after an accepted host read.
  always_comb begin
    rvalid_nxt = host_grant & ~host_we;
    rdata_nxt  = host_rdata;
    if (rvalid_nxt) begin
      rdata_nxt = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      wait_cnt    <= wait_cnt_nxt;
      host_rvalid <= rvalid_nxt;
      host_rdata  <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with MAX_WAIT=4, one with MAX_WAIT=0,
// each driving its own behavioural data memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_memread;
  logic        cpu_memwrite;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        host_valid;
  logic        host_we;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;

  logic [31:0] cpu_rdata_a, host_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic        cpu_stall_a, host_ready_a, host_rvalid_a, mem_we_a;
  logic [31:0] cpu_rdata_z, host_rdata_z, mem_addr_z, mem_wdata_z, mem_rdata_z;
  logic        cpu_stall_z, host_ready_z, host_rvalid_z, mem_we_z;

  logic [31:0] mem_a [0:255];
  logic [31:0] mem_z [0:255];
  logic [31:0] rd_addr [0:2];
  logic [31:0] rd_data [0:2];

  int n_cmp = 0;
  int n_err = 0;

  dmem_arbiter #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata_a), .cpu_stall(cpu_stall_a),
    .host_valid(host_valid), .host_ready(host_ready_a), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rvalid(host_rvalid_a), .host_rdata(host_rdata_a),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a)
  );

  dmem_arbiter #(.MAX_WAIT(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata_z), .cpu_stall(cpu_stall_z),
    .host_valid(host_valid), .host_ready(host_ready_z), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rvalid(host_rvalid_z), .host_rdata(host_rdata_z),
    .mem_we(mem_we_z), .mem_addr(mem_addr_z), .mem_wdata(mem_wdata_z),
    .mem_rdata(mem_rdata_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-indexed memories with combinational read; preloaded while in reset.
  assign mem_rdata_a = mem_a[mem_addr_a[9:2]];
  assign mem_rdata_z = mem_z[mem_addr_z[9:2]];

  always @(posedge clk) begin
    if (!rst_n) begin
      mem_a[16]  <= 32'hDEAD_BEEF;
      mem_a[192] <= 32'h0;
      mem_z[16]  <= 32'hDEAD_BEEF;
      mem_z[128] <= 32'hA000_0000;
      mem_z[129] <= 32'hA111_1111;
      mem_z[130] <= 32'hA222_2222;
    end else begin
      if (mem_we_a) mem_a[mem_addr_a[9:2]] <= mem_wdata_a;
      if (mem_we_z) mem_z[mem_addr_z[9:2]] <= mem_wdata_z;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rd_addr[0] = 32'h200; rd_data[0] = 32'hA000_0000;
    rd_addr[1] = 32'h204; rd_data[1] = 32'hA111_1111;
    rd_addr[2] = 32'h208; rd_data[2] = 32'hA222_2222;
    rst_n = 1'b0; cpu_memread = 1'b0; cpu_memwrite = 1'b0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0;
    host_valid = 1'b0; host_we = 1'b0; host_addr = 32'h0; host_wdata = 32'h0;

    // Reset state
    repeat (2) tick();
    chkb("rst_rvalid", host_rvalid_a, 1'b0);
    chk ("rst_rdata", host_rdata_a, 32'h0);
    chkb("rst_stall", cpu_stall_a, 1'b0);
    chkb("rst_ready", host_ready_a, 1'b0);
    chk ("rst_wait", 32'(dut.wait_cnt), 32'h0);
    rst_n = 1'b1;
    tick();

    // Core idle: host read of 0x40 accepted immediately
    host_valid = 1'b1; host_we = 1'b0; host_addr = 32'h40;
    mid();
    chkb("idle_ready", host_ready_a, 1'b1);
    chkb("idle_stall", cpu_stall_a, 1'b0);
    chk ("idle_maddr", mem_addr_a, 32'h40);
    chkb("idle_mwe", mem_we_a, 1'b0);
    tick();
    host_valid = 1'b0;
    chkb("idle_rvalid", host_rvalid_a, 1'b1);
    chk ("idle_rdata", host_rdata_a, 32'hDEAD_BEEF);
    chk ("idle_wait", 32'(dut.wait_cnt), 32'h0);
    tick();
    chkb("idle_rvalid_off", host_rvalid_a, 1'b0);
    chk ("idle_rdata_hold", host_rdata_a, 32'hDEAD_BEEF);

    // Core loads every cycle; host write forced through on its 5th cycle
    cpu_memread = 1'b1; cpu_addr = 32'h100;
    host_valid = 1'b1; host_we = 1'b1; host_addr = 32'h80; host_wdata = 32'h1234;
    for (int k = 0; k < 4; k++) begin
      mid();
      chkb($sformatf("starve_ready%0d", k), host_ready_a, 1'b0);
      chkb($sformatf("starve_stall%0d", k), cpu_stall_a, 1'b0);
      chk ($sformatf("starve_wait%0d", k), 32'(dut.wait_cnt), 32'(k));
      chk ($sformatf("starve_maddr%0d", k), mem_addr_a, 32'h100);
      tick();
    end
    mid();
    chkb("force_ready", host_ready_a, 1'b1);
    chkb("force_stall", cpu_stall_a, 1'b1);
    chkb("force_mwe", mem_we_a, 1'b1);
    chk ("force_maddr", mem_addr_a, 32'h80);
    chk ("force_mwdata", mem_wdata_a, 32'h1234);
    tick();
    host_valid = 1'b0; host_we = 1'b0;
    mid();
    chkb("force_stall_off", cpu_stall_a, 1'b0);
    chk ("force_wait_clr", 32'(dut.wait_cnt), 32'h0);
    chk ("force_memdata", mem_a[32], 32'h1234);
    chkb("force_no_rvalid", host_rvalid_a, 1'b0);
    tick();

    // Core store wins while the host waits, then host read goes through
    cpu_memread = 1'b0; cpu_memwrite = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hAAAA;
    host_valid = 1'b1; host_we = 1'b0; host_addr = 32'h40;
    mid();
    chkb("cst_mwe", mem_we_a, 1'b1);
    chk ("cst_maddr", mem_addr_a, 32'h10);
    chk ("cst_mwdata", mem_wdata_a, 32'hAAAA);
    chkb("cst_ready", host_ready_a, 1'b0);
    chk ("cst_wait0", 32'(dut.wait_cnt), 32'h0);
    tick();
    mid();
    chk ("cst_wait1", 32'(dut.wait_cnt), 32'h1);
    chkb("cst_ready1", host_ready_a, 1'b0);
    tick();
    cpu_memwrite = 1'b0;
    mid();
    chkb("cst_host_ready", host_ready_a, 1'b1);
    chkb("cst_host_stall", cpu_stall_a, 1'b0);
    chk ("cst_memdata", mem_a[4], 32'hAAAA);
    tick();
    host_valid = 1'b0;
    chkb("cst_rvalid", host_rvalid_a, 1'b1);
    chk ("cst_rdata", host_rdata_a, 32'hDEAD_BEEF);

    // MAX_WAIT=0: host wins every cycle, back-to-back read pulses
    cpu_memread = 1'b1; cpu_addr = 32'h100;
    host_valid = 1'b1; host_we = 1'b0;
    for (int j = 0; j < 3; j++) begin
      host_addr = rd_addr[j];
      mid();
      chkb($sformatf("mw0_ready%0d", j), host_ready_z, 1'b1);
      chkb($sformatf("mw0_stall%0d", j), cpu_stall_z, 1'b1);
      chk ($sformatf("mw0_maddr%0d", j), mem_addr_z, rd_addr[j]);
      chkb($sformatf("mw4_ready%0d", j), host_ready_a, 1'b0);
      tick();
      chkb($sformatf("mw0_rvalid%0d", j), host_rvalid_z, 1'b1);
      chk ($sformatf("mw0_rdata%0d", j), host_rdata_z, rd_data[j]);
    end
    host_valid = 1'b0;
    tick();
    chkb("mw0_rvalid_off", host_rvalid_z, 1'b0);
    chk ("mw4_wait_clr", 32'(dut.wait_cnt), 32'h0);

    // Host abandons after 2 cycles, then re-request waits the full budget
    host_valid = 1'b1; host_we = 1'b1; host_addr = 32'h300; host_wdata = 32'h55;
    for (int k = 0; k < 2; k++) begin
      mid();
      chkb($sformatf("abn_ready%0d", k), host_ready_a, 1'b0);
      chkb($sformatf("abn_mwe%0d", k), mem_we_a, 1'b0);
      tick();
    end
    host_valid = 1'b0;
    mid();
    chk ("abn_wait2", 32'(dut.wait_cnt), 32'h2);
    tick();
    mid();
    chk ("abn_wait_clr", 32'(dut.wait_cnt), 32'h0);
    chk ("abn_mem_untouched", mem_a[192], 32'h0);
    tick();
    host_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mid();
      chkb($sformatf("rereq_ready%0d", k), host_ready_a, 1'b0);
      tick();
    end
    mid();
    chkb("rereq_ready", host_ready_a, 1'b1);
    chkb("rereq_stall", cpu_stall_a, 1'b1);
    tick();
    host_valid = 1'b0; host_we = 1'b0;
    mid();
    chk ("rereq_memdata", mem_a[192], 32'h55);
    tick();

    // Reset right after a read is accepted discards the return
    cpu_memread = 1'b0;
    host_valid = 1'b1; host_we = 1'b0; host_addr = 32'h40;
    mid();
    chkb("rmid_ready", host_ready_a, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chkb("rmid_rvalid_async", host_rvalid_a, 1'b0);
    chk ("rmid_rdata_async", host_rdata_a, 32'h0);
    tick();
    chkb("rmid_rvalid", host_rvalid_a, 1'b0);
    host_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chkb("rmid_rvalid_rel", host_rvalid_a, 1'b0);
    chk ("rmid_rdata_rel", host_rdata_a, 32'h0);
    chk ("rmid_wait_rel", 32'(dut.wait_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
